// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: operation codes,
// FSM state encoding and small decode helpers.
package mul_div_unit_pkg;

    localparam int MDOP_WIDTH = 2;

    // Operation select presented alongside Start.
    typedef enum logic [MDOP_WIDTH-1:0] {
        MDOP_MULT  = 2'b00,
        MDOP_MULTU = 2'b01,
        MDOP_DIV   = 2'b10,
        MDOP_DIVU  = 2'b11
    } md_op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_ITER = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    // Low bit clear means the signed flavour of the operation.
    function automatic logic md_op_signed(input logic [MDOP_WIDTH-1:0] op);
        return ~op[0];
    endfunction

    // High bit set selects divide, clear selects multiply.
    function automatic logic md_op_div(input logic [MDOP_WIDTH-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate. Used as an absolute-value stage on the
// operands at load time and as the sign correction on the results at FIX.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    // Negate when asked, otherwise pass straight through.
    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with its own HI/LO registers.
//
// Handshake: Start is accepted only at a rising edge where Busy=0 (IDLE) and
// Flush=0; the operands A/B/MdOp are captured at that same edge and need not be
// held. Busy stays high until the result is committed; Done then pulses for
// exactly one cycle, in which Busy=0 and Hi/Lo already show the new result, so
// a new Start may be presented in that cycle. Flush aborts with no result and
// no Done. HiWe/LoWe are plain register writes taken only while idle and not
// starting.
//
// One shared 2*DP_WIDTH accumulator carries both algorithms:
//   multiply: {partial product high, multiplier bits not yet consumed}
//   divide:   {partial remainder, dividend bits shifting out / quotient in}
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int DP_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [MDOP_WIDTH-1:0] MdOp,
    input  logic [DP_WIDTH-1:0]   A,
    input  logic [DP_WIDTH-1:0]   B,
    input  logic                  HiWe,
    input  logic                  LoWe,
    input  logic                  Flush,
    output logic                  Busy,
    output logic                  Done,
    output logic [DP_WIDTH-1:0]   Hi,
    output logic [DP_WIDTH-1:0]   Lo,
    output md_state_e             dbg_state
);

    localparam int CW = $clog2(DP_WIDTH);
    localparam int AW = 2 * DP_WIDTH;

    md_state_e state, state_nxt;

    logic [CW-1:0]       count;
    logic                count_last;
    logic                load;

    logic [AW-1:0]       acc_q;
    logic [DP_WIDTH-1:0] opnd_q;      // multiplicand or divisor (magnitude)
    logic [DP_WIDTH-1:0] raw_a_q;     // dividend as presented, for divide-by-zero
    logic                is_div_q;
    logic                div0_q;
    logic                neg_res_q;   // product / quotient sign
    logic                neg_rem_q;   // remainder sign

    logic                op_signed;
    logic                op_div;
    logic [DP_WIDTH-1:0] abs_a;
    logic [DP_WIDTH-1:0] abs_b;

    logic [DP_WIDTH:0]   mul_sum;
    logic [AW-1:0]       mul_next;
    logic [DP_WIDTH:0]   div_shift;
    logic [DP_WIDTH:0]   div_diff;
    logic                div_ge;
    logic [DP_WIDTH-1:0] div_rem;
    logic [AW-1:0]       div_next;

    logic [AW-1:0]       prod_fix;
    logic [DP_WIDTH-1:0] quo_fix;
    logic [DP_WIDTH-1:0] rem_fix;

    logic [DP_WIDTH-1:0] hi_q;
    logic [DP_WIDTH-1:0] lo_q;
    logic                done_q;

    assign op_signed  = md_op_signed(MdOp);
    assign op_div     = md_op_div(MdOp);
    assign load       = (state == MD_IDLE) && Start && !Flush;
    assign count_last = (count == CW'(DP_WIDTH - 1));

    // Operand magnitudes for the signed flavours.
    md_sign_fix #(.W(DP_WIDTH)) u_abs_a (
        .value  (A),
        .neg    (op_signed & A[DP_WIDTH-1]),
        .result (abs_a)
    );

    md_sign_fix #(.W(DP_WIDTH)) u_abs_b (
        .value  (B),
        .neg    (op_signed & B[DP_WIDTH-1]),
        .result (abs_b)
    );

    // Result sign correction: full-width product, or quotient and remainder.
    md_sign_fix #(.W(AW)) u_fix_prod (
        .value  (acc_q),
        .neg    (neg_res_q),
        .result (prod_fix)
    );

    md_sign_fix #(.W(DP_WIDTH)) u_fix_quo (
        .value  (acc_q[DP_WIDTH-1:0]),
        .neg    (neg_res_q),
        .result (quo_fix)
    );

    md_sign_fix #(.W(DP_WIDTH)) u_fix_rem (
        .value  (acc_q[AW-1:DP_WIDTH]),
        .neg    (neg_rem_q),
        .result (rem_fix)
    );

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[AW-1:DP_WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[DP_WIDTH-1:1]};
        div_shift = acc_q[AW-1:DP_WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[DP_WIDTH];
        div_rem   = div_ge ? div_diff[DP_WIDTH-1:0] : div_shift[DP_WIDTH-1:0];
        div_next  = {div_rem, acc_q[DP_WIDTH-2:0], div_ge};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state and Busy decode; Flush always returns to IDLE.
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (Start && !Flush) state_nxt = MD_ITER;
            end
            MD_ITER: begin
                Busy = 1'b1;
                if (Flush)           state_nxt = MD_IDLE;
                else if (count_last) state_nxt = MD_FIX;
            end
            MD_FIX: begin
                Busy      = 1'b1;
                state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    // Iteration counter: runs only while iterating, zero everywhere else.
    always_ff @(posedge clk) begin
        if (rst || state != MD_ITER) count <= '0;
        else                         count <= count + CW'(1);
    end

    // Operand capture at Start and the per-cycle shift datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            opnd_q    <= '0;
            raw_a_q   <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (load) begin
            acc_q     <= {{DP_WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
            opnd_q    <= op_div ? abs_b : abs_a;
            raw_a_q   <= A;
            is_div_q  <= op_div;
            div0_q    <= op_div && (B == '0);
            neg_res_q <= op_signed & (A[DP_WIDTH-1] ^ B[DP_WIDTH-1]);
            neg_rem_q <= op_signed & A[DP_WIDTH-1];
        end else if (state == MD_ITER) begin
            acc_q     <= is_div_q ? div_next : mul_next;
        end
    end

    // HI/LO registers and the Done pulse: commit at FIX, direct writes when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == MD_FIX) && !Flush;
            if (state == MD_FIX && !Flush) begin
                if (div0_q) begin
                    hi_q <= raw_a_q;
                    lo_q <= '1;
                end else if (is_div_q) begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end else begin
                    hi_q <= prod_fix[AW-1:DP_WIDTH];
                    lo_q <= prod_fix[DP_WIDTH-1:0];
                end
            end else if (state == MD_IDLE && !Start) begin
                if (HiWe) hi_q <= A;
                if (LoWe) lo_q <= A;
            end
        end
    end

    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign Done      = done_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit: fixed vectors with hand-computed
// HI/LO results, cycle-exact Busy/Done timing, flush, reset and HI/LO writes.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          Start;
    logic [1:0]    MdOp;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          HiWe;
    logic          LoWe;
    logic          Flush;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  Hi;
    logic [W-1:0]  Lo;
    md_state_e     dbg_state;

    int n_asserts = 0;
    int n_fail    = 0;

    mul_div_unit #(.DP_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .MdOp      (MdOp),
        .A         (A),
        .B         (B),
        .HiWe      (HiWe),
        .LoWe      (LoWe),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .Hi        (Hi),
        .Lo        (Lo),
        .dbg_state (dbg_state)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an operation for one edge, then scramble the operand inputs.
    // Returns in cycle N+1, where N is the cycle whose end sampled Start.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        MdOp  = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        step();
        Start = 1'b0;
        A     = $urandom();
        B     = $urandom();
        MdOp  = 2'($urandom_range(0, 3));
    endtask

    // From cycle N+cyc, check Busy through N+33, then the result at N+34
    // and the end of the Done pulse at N+35.
    task automatic expect_result(input string tag, input int cyc,
                                 input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        for (int c = cyc; c < 34; c++) begin
            check({tag, "_busy"}, 64'(Busy), 64'd1);
            check({tag, "_nodone"}, 64'(Done), 64'd0);
            step();
        end
        check({tag, "_done"}, 64'(Done), 64'd1);
        check({tag, "_idle"}, 64'(Busy), 64'd0);
        check({tag, "_hi"}, 64'(Hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(Lo), 64'(exp_lo));
        step();
        check({tag, "_pulse"}, 64'(Done), 64'd0);
        check({tag, "_stay_idle"}, 64'(Busy), 64'd0);
    endtask

    // Hold for n cycles checking that no Done appears.
    task automatic quiet(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            step();
            check(tag, 64'(Done), 64'd0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        Start = 1'b0;
        MdOp  = 2'b00;
        A     = '0;
        B     = '0;
        HiWe  = 1'b0;
        LoWe  = 1'b0;
        Flush = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(MD_IDLE));

        // Multu max x max, with exact timing.
        start_op(MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_state_iter", 64'(dbg_state), 64'(MD_ITER));
        expect_result("multu_max", 1, 32'hFFFF_FFFE, 32'h0000_0001);

        // Signed multiply and divide with mixed signs.
        start_op(MDOP_MULT, 32'hFFFF_FFFD, 32'd7);
        expect_result("mult_neg3x7", 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        start_op(MDOP_DIV, 32'hFFFF_FFF9, 32'd2);
        expect_result("div_neg7by2", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        start_op(MDOP_DIV, 32'd7, 32'hFFFF_FFFE);
        expect_result("div_7byneg2", 1, 32'h0000_0001, 32'hFFFF_FFFD);

        start_op(MDOP_MULT, 32'h8000_0000, 32'h8000_0000);
        expect_result("mult_minxmin", 1, 32'h4000_0000, 32'h0000_0000);

        // Divide by zero, unsigned and signed: Hi is the raw dividend.
        start_op(MDOP_DIVU, 32'd100, 32'd0);
        expect_result("divu_by0", 1, 32'd100, 32'hFFFF_FFFF);

        start_op(MDOP_DIV, 32'hFFFF_FF9C, 32'd0);
        expect_result("div_neg_by0", 1, 32'hFFFF_FF9C, 32'hFFFF_FFFF);

        // Most negative divided by -1.
        start_op(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_result("div_min_byneg1", 1, 32'h0000_0000, 32'h8000_0000);

        start_op(MDOP_DIVU, 32'd100, 32'd7);
        expect_result("divu_100by7", 1, 32'd2, 32'd14);

        // Flush at cycle N+10: idle at N+11, Hi/Lo kept, no Done.
        start_op(MDOP_DIVU, 32'd100, 32'd7);
        repeat (9) step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("flush_busy", 64'(Busy), 64'd0);
        check("flush_done", 64'(Done), 64'd0);
        check("flush_state", 64'(dbg_state), 64'(MD_IDLE));
        check("flush_hi", 64'(Hi), 64'd2);
        check("flush_lo", 64'(Lo), 64'd14);
        quiet("flush_nodone", 30);
        check("flush_hi_after", 64'(Hi), 64'd2);
        check("flush_lo_after", 64'(Lo), 64'd14);

        // mthi / mtlo while idle.
        A    = 32'h1234_5678;
        HiWe = 1'b1;
        step();
        HiWe = 1'b0;
        check("mthi_hi", 64'(Hi), 64'h1234_5678);
        check("mthi_lo", 64'(Lo), 64'd14);
        A    = 32'h0BAD_F00D;
        LoWe = 1'b1;
        step();
        LoWe = 1'b0;
        check("mtlo_lo", 64'(Lo), 64'h0BAD_F00D);
        check("mtlo_hi", 64'(Hi), 64'h1234_5678);

        // Start together with HiWe: the write is dropped.
        HiWe = 1'b1;
        start_op(MDOP_MULTU, 32'd5, 32'd3);
        HiWe = 1'b0;
        check("start_hiwe_hi", 64'(Hi), 64'h1234_5678);
        expect_result("multu_5x3", 1, 32'd0, 32'd15);

        // HiWe/LoWe and a second Start while busy are ignored.
        start_op(MDOP_MULTU, 32'd6, 32'd7);
        repeat (3) step();
        Start = 1'b1;
        MdOp  = MDOP_DIVU;
        A     = 32'hDEAD_BEEF;
        B     = 32'd1;
        HiWe  = 1'b1;
        LoWe  = 1'b1;
        step();
        Start = 1'b0;
        HiWe  = 1'b0;
        LoWe  = 1'b0;
        check("busy_hiwe_hi", 64'(Hi), 64'd0);
        check("busy_lowe_lo", 64'(Lo), 64'd15);
        expect_result("multu_6x7", 5, 32'd0, 32'd42);

        // Start with Flush while idle: stays idle.
        Start = 1'b1;
        Flush = 1'b1;
        MdOp  = MDOP_MULTU;
        A     = 32'd2;
        B     = 32'd2;
        step();
        Start = 1'b0;
        Flush = 1'b0;
        check("start_flush_busy", 64'(Busy), 64'd0);
        check("start_flush_state", 64'(dbg_state), 64'(MD_IDLE));
        quiet("start_flush_nodone", 40);
        check("start_flush_lo", 64'(Lo), 64'd42);

        // Reset mid-operation clears Hi/Lo and writes no result.
        start_op(MDOP_MULT, 32'd9, 32'd9);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_done", 64'(Done), 64'd0);
        check("midrst_hi", 64'(Hi), 64'd0);
        check("midrst_lo", 64'(Lo), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(MD_IDLE));
        quiet("midrst_nodone", 40);
        check("midrst_lo_after", 64'(Lo), 64'd0);

        // Unit works normally after the mid-op reset.
        start_op(MDOP_DIVU, 32'd100, 32'd7);
        expect_result("post_rst_divu", 1, 32'd2, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the 32-bit ALU.
- Executes mult, multu, div and divu on the same A/B operands the ALU receives.
- Also executes mthi/mtlo.
- Owns the HI/LO registers.
- Its Hi/Lo outputs feed the EX result mux for mfhi/mflo.
- Busy drives the pipeline stall logic.

Parameters:
- DP_WIDTH, 32, datapath width. Iteration count equals DP_WIDTH.

Ports:
- clk  input  1  system clock; rising-edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  begin operation MdOp on A/B; sampled only when idle.
- MdOp  input  2  00 Mult, 01 Multu, 10 Div, 11 Divu.
- A  input  DP_WIDTH  rs operand (multiplicand / dividend).
- B  input  DP_WIDTH  rt operand (multiplier / divisor).
- HiWe  input  1  mthi: load Hi from A.
- LoWe  input  1  mtlo: load Lo from A.
- Flush  input  1  abort any in-flight operation.
- Busy  output  1  operation in progress; stall mfhi/mflo/new md ops.
- Done  output  1  one-cycle pulse; Hi/Lo hold the new result.
- Hi  output  DP_WIDTH  HI register.
- Lo  output  DP_WIDTH  LO register.

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE, Hi=0, Lo=0, Busy=0, Done=0, counter=0.
  - Reset overrides everything, including mid-operation; no result is written.
- States:
  - IDLE -> ITER on Start & !Flush.
  - ITER -> ITER while count < DP_WIDTH-1.
  - ITER -> FIX when count = DP_WIDTH-1.
  - FIX -> IDLE.
  - Flush in ITER or FIX -> IDLE.
- Busy = 1 in ITER and FIX. Done is registered and asserted in the cycle after FIX.
- Timing, with Start sampled at the end of cycle N:
  - Busy=1 in cycles N+1..N+33.
  - Done=1 and new Hi/Lo visible in cycle N+34.
  - Busy=0 in cycle N+34.
  - A new Start may be sampled in cycle N+34.
- Load edge:
  - Signed ops take absolute values of A and B.
  - Result signs are recorded: quotient/product sign = A[31]^B[31]; remainder sign = A[31].
  - Unsigned ops use raw operands.
  - A and B need not be held after the Start cycle.
- Multiply: radix-2 shift-add over a 2*DP_WIDTH accumulator, one bit per ITER cycle.
- Divide: restoring, one quotient bit per ITER cycle.
  - Partial remainder is DP_WIDTH+1 bits wide.
- FIX edge:
  - Applies two's-complement negation per the recorded signs.
  - Writes Hi/Lo.
  - Multiply: Hi = product[63:32], Lo = product[31:0].
  - Divide: Lo = quotient, Hi = remainder.
- Divide by zero (B=0, signed or unsigned): Lo=0xFFFFFFFF, Hi=A as presented at Start. No sign fix, no exception.
- Signed 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. No exception.
- Start while Busy: ignored. Start with Flush in the same cycle: Flush wins, stays IDLE.
- HiWe/LoWe:
  - Honoured only in IDLE with Start=0; the register updates at the next edge.
  - Ignored while Busy.
  - Start & HiWe/LoWe together: Start wins, the write is dropped.
- Flush mid-operation:
  - Returns to IDLE next edge; Busy=0 next cycle.
  - Hi/Lo unchanged; Done never asserted for the aborted op.
- MdOp and Start are don't-care when not idle.

Decomposition:
- cpu_para.v gains MDOP_WIDTH=2 and the MdOp_Mult/Multu/Div/Divu encodings.
- cpu_para.v also gains the state encodings Md_Idle/Md_Iter/Md_Fix.
- One natural sub-module: md_sign_fix, a combinational conditional negate (abs on load, negate on FIX).
  - It is instantiated for operand and result correction.
- The FSM, counter and shift datapath stay in mul_div_unit.

Test Plan:
- Multu 0xFFFFFFFF x 0xFFFFFFFF, Start at cycle N -> Busy in N+1..N+33; Done in N+34 with Hi=0xFFFFFFFE, Lo=0x00000001.
- Mult 0xFFFFFFFD (-3) x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Div -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- Divu 100 / 0 -> Lo=0xFFFFFFFF, Hi=100.
- Div 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Divu 100/7 started, Flush asserted at cycle N+10 -> Busy=0 at N+11; Hi/Lo keep their prior values; no Done.
- Then rst mid-op -> Hi=Lo=0.
- In IDLE: HiWe=1, A=0x12345678 -> Hi=0x12345678 next cycle.
- HiWe during Busy -> no change.
- Start during Busy -> ignored; the first op's result is unaffected.
